// File: rtl/hssl_reg_arbiter.sv
// rtl/hssl_reg_arbiter.sv - shares the hssl register-bank port between APB and buffered packet writes
// Packet writes win unless the FIFO is empty or an APB request has waited MAX_PRX_BURST pops.
module hssl_reg_arbiter #(
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_PRX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        apb_psel_in,
  input  logic                        apb_penable_in,
  input  logic                        apb_pwrite_in,
  input  logic [39:0]                 apb_paddr_in,
  input  logic [31:0]                 apb_pwdata_in,
  output logic [31:0]                 apb_prdata_out,
  output logic                        apb_pready_out,
  output logic                        apb_pslverr_out,
  input  logic [7:0]                  prx_addr_in,
  input  logic [31:0]                 prx_wdata_in,
  input  logic                        prx_vld_in,
  output logic                        prx_rdy_out,
  output logic [7:0]                  rb_addr_out,
  output logic [31:0]                 rb_wdata_out,
  output logic                        rb_wen_out,
  output logic                        rb_ren_out,
  input  logic [31:0]                 rb_rdata_in,
  output logic [$clog2(FIFO_DEPTH):0] prx_fifo_lvl_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_PRX_BURST + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RD_WAIT, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [7:0]    r_fifo_addr [FIFO_DEPTH];
  logic [31:0]   r_fifo_data [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_cnt, w_cnt_nxt;
  logic [BW-1:0] r_burst;
  logic          r_rdy, r_is_write;
  logic [31:0]   r_prdata, r_rb_wdata;
  logic [7:0]    r_rb_addr;
  logic          r_pready, r_pslverr, r_rb_wen, r_rb_ren;

  logic w_access, w_apb_req, w_apb_err, w_empty, w_burst_max;
  logic w_apb_grant, w_pop, w_push;
  logic w_unused;

  assign w_unused    = &{1'b0, apb_paddr_in[39:9], apb_paddr_in[1:0]};
  assign w_access    = (r_state == S_IDLE) && apb_psel_in && apb_penable_in;
  assign w_apb_req   = w_access && (apb_paddr_in[8:6] != 3'd7);
  assign w_apb_err   = w_access && (apb_paddr_in[8:6] == 3'd7);
  assign w_empty     = (r_cnt == '0);
  assign w_burst_max = (r_burst == BW'(MAX_PRX_BURST));
  assign w_apb_grant = w_apb_req && (w_empty || w_burst_max);
  // A pop only steals the next rb cycle when APB is not being granted it.
  assign w_pop       = !w_empty && !w_apb_grant;
  assign w_push      = prx_vld_in && r_rdy;
  assign w_cnt_nxt   = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_apb_grant)    w_state_nxt = S_ISSUE;
        else if (w_apb_err) w_state_nxt = S_DONE;
      end
      S_ISSUE:   w_state_nxt = r_is_write ? S_DONE : S_RD_WAIT;
      S_RD_WAIT: w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= prx_addr_in;
      r_fifo_data[r_wr_ptr] <= prx_wdata_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_burst    <= '0;
      r_rdy      <= 1'b0;
      r_is_write <= 1'b0;
      r_prdata   <= '0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_rb_wen   <= 1'b0;
      r_rb_ren   <= 1'b0;
      r_rb_addr  <= '0;
      r_rb_wdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rdy     <= (w_cnt_nxt != (AW+1)'(FIFO_DEPTH));
      r_pready  <= (w_state_nxt == S_DONE);
      r_pslverr <= w_apb_err;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      if (!w_apb_req || w_apb_grant) r_burst <= '0;
      else if (w_pop && !w_burst_max) r_burst <= r_burst + BW'(1);

      if (r_state == S_RD_WAIT) r_prdata <= rb_rdata_in;

      r_rb_wen <= 1'b0;
      r_rb_ren <= 1'b0;
      if (w_apb_grant) begin
        r_is_write <= apb_pwrite_in;
        r_rb_wen   <= apb_pwrite_in;
        r_rb_ren   <= !apb_pwrite_in;
        r_rb_addr  <= {1'b0, apb_paddr_in[8:2]};
        r_rb_wdata <= apb_pwdata_in;
      end else if (w_pop) begin
        r_rb_wen   <= 1'b1;
        r_rb_addr  <= r_fifo_addr[r_rd_ptr];
        r_rb_wdata <= r_fifo_data[r_rd_ptr];
      end
    end
  end

  assign apb_prdata_out   = r_prdata;
  assign apb_pready_out   = r_pready;
  assign apb_pslverr_out  = r_pslverr;
  assign prx_rdy_out      = r_rdy;
  assign rb_addr_out      = r_rb_addr;
  assign rb_wdata_out     = r_rb_wdata;
  assign rb_wen_out       = r_rb_wen;
  assign rb_ren_out       = r_rb_ren;
  assign prx_fifo_lvl_out = r_cnt;
endmodule

// File: tb/tb_hssl_reg_arbiter.sv
// tb/tb_hssl_reg_arbiter.sv - directed self-checking bench for hssl_reg_arbiter
module tb_hssl_reg_arbiter;
  logic        clk;
  logic        resetn = 1'b0;
  logic        apb_psel_in = 1'b0, apb_penable_in = 1'b0, apb_pwrite_in = 1'b0;
  logic [39:0] apb_paddr_in = '0;
  logic [31:0] apb_pwdata_in = '0;
  logic [31:0] apb_prdata_out;
  logic        apb_pready_out, apb_pslverr_out;
  logic [7:0]  prx_addr_in = '0;
  logic [31:0] prx_wdata_in = '0;
  logic        prx_vld_in = 1'b0;
  logic        prx_rdy_out;
  logic [7:0]  rb_addr_out;
  logic [31:0] rb_wdata_out;
  logic        rb_wen_out, rb_ren_out;
  logic [31:0] rb_rdata_in = 32'hDEAD_BEEF;
  logic [2:0]  prx_fifo_lvl_out;

  hssl_reg_arbiter #(.FIFO_DEPTH(4), .MAX_PRX_BURST(4)) dut (
    .clk(clk), .resetn(resetn),
    .apb_psel_in(apb_psel_in), .apb_penable_in(apb_penable_in), .apb_pwrite_in(apb_pwrite_in),
    .apb_paddr_in(apb_paddr_in), .apb_pwdata_in(apb_pwdata_in), .apb_prdata_out(apb_prdata_out),
    .apb_pready_out(apb_pready_out), .apb_pslverr_out(apb_pslverr_out),
    .prx_addr_in(prx_addr_in), .prx_wdata_in(prx_wdata_in), .prx_vld_in(prx_vld_in),
    .prx_rdy_out(prx_rdy_out), .rb_addr_out(rb_addr_out), .rb_wdata_out(rb_wdata_out),
    .rb_wen_out(rb_wen_out), .rb_ren_out(rb_ren_out), .rb_rdata_in(rb_rdata_in),
    .prx_fifo_lvl_out(prx_fifo_lvl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic        push_en = 1'b0;
  int          seq = 0;
  int          max_lvl = 0;
  logic [39:0] exp_q[$];

  typedef struct {
    logic [39:0] paddr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  exp_addr;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          lat;
    int          strobe_n;
    int          pkts;
    logic [31:0] prdata;
    logic        err;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata;
    logic        s_wr;
  } res_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: wait for the negedge, check invariants and packet order, then drive the packet source.
  task automatic tick();
    logic [39:0] e;
    @(negedge clk);
    if (resetn) begin
      check("rdy_vs_lvl", prx_rdy_out, prx_fifo_lvl_out != 3'd4);
      if (int'(prx_fifo_lvl_out) > max_lvl) max_lvl = int'(prx_fifo_lvl_out);
    end else begin
      check("rst_no_strobe", rb_wen_out | rb_ren_out, 1'b0);
      exp_q.delete();
    end
    check("rb_excl", rb_wen_out & rb_ren_out, 1'b0);
    if (rb_wen_out && rb_wdata_out[31:28] == 4'h5) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pkt_extra: got addr 0x%0h data 0x%0h, expected no packet", rb_addr_out, rb_wdata_out);
      end else begin
        e = exp_q.pop_front();
        check("pkt_order", {rb_addr_out, rb_wdata_out}, e);
      end
    end
    if (push_en) begin
      prx_vld_in   = 1'b1;
      prx_addr_in  = {1'b0, seq[6:0]};
      prx_wdata_in = 32'h5000_0000 | seq;
      if (prx_rdy_out) begin
        exp_q.push_back({prx_addr_in, prx_wdata_in});
        seq++;
      end
    end else begin
      prx_vld_in = 1'b0;
    end
  endtask

  task automatic apb_xfer(input logic [39:0] paddr, input logic wr, input logic [31:0] wdata,
                          input logic [31:0] rdata, output res_t r);
    r = '{lat: -1, strobe_n: -1, pkts: 0, prdata: '0, err: 1'b0, s_addr: '0, s_wdata: '0, s_wr: 1'b0};
    tick();
    apb_psel_in = 1'b1; apb_penable_in = 1'b0; apb_pwrite_in = wr;
    apb_paddr_in = paddr; apb_pwdata_in = wdata;
    tick();
    apb_penable_in = 1'b1;
    for (int n = 1; n <= 40 && r.lat < 0; n++) begin
      tick();
      if (rb_ren_out || (rb_wen_out && rb_wdata_out[31:28] != 4'h5)) begin
        if (r.strobe_n < 0) begin
          r.strobe_n = n; r.s_addr = rb_addr_out; r.s_wdata = rb_wdata_out; r.s_wr = rb_wen_out;
        end
      end else if (rb_wen_out && r.strobe_n < 0) begin
        r.pkts++;
      end
      // Read data is valid only in the cycle after the read strobe.
      rb_rdata_in = (r.strobe_n > 0 && n == r.strobe_n + 1 && !r.s_wr) ? rdata : 32'hDEAD_BEEF;
      if (apb_pready_out) begin
        r.lat = n; r.prdata = apb_prdata_out; r.err = apb_pslverr_out;
        apb_psel_in = 1'b0; apb_penable_in = 1'b0;
      end
    end
    rb_rdata_in = 32'hDEAD_BEEF;
  endtask

  initial begin
    vec_t vecs[7];
    res_t r;
    logic seen;
    int   waited;

    vecs[0] = '{40'h010,          1'b1, 32'hA5A5_0001, 32'h0,         8'h04, 2, 1'b0};
    vecs[1] = '{40'h0C4,          1'b0, 32'h0,         32'h0000_0005, 8'h31, 3, 1'b0};
    vecs[2] = '{40'h1C0,          1'b1, 32'h7777_0000, 32'h0,         8'h00, 1, 1'b1};
    vecs[3] = '{40'hFF_FFFF_FE7C, 1'b1, 32'h1234_5678, 32'h0,         8'h1F, 2, 1'b0};
    vecs[4] = '{40'h183,          1'b0, 32'h0,         32'hCAFE_F00D, 8'h60, 3, 1'b0};
    vecs[5] = '{40'h1FC,          1'b0, 32'h0,         32'h0,         8'h00, 1, 1'b1};
    vecs[6] = '{40'h13C,          1'b1, 32'h0BAD_0013, 32'h0,         8'h4F, 2, 1'b0};

    // Reset state
    repeat (3) tick();
    check("rst_pready", apb_pready_out, 1'b0);
    check("rst_pslverr", apb_pslverr_out, 1'b0);
    check("rst_prdata", apb_prdata_out, 32'h0);
    check("rst_rdy", prx_rdy_out, 1'b0);
    check("rst_lvl", prx_fifo_lvl_out, 3'd0);
    check("rst_rb_addr", rb_addr_out, 8'h0);
    check("rst_rb_wdata", rb_wdata_out, 32'h0);
    resetn = 1'b1;
    tick();
    check("rdy_after_rst", prx_rdy_out, 1'b1);

    // Single APB accesses with the FIFO empty
    for (int i = 0; i < 7; i++) begin
      apb_xfer(vecs[i].paddr, vecs[i].wr, vecs[i].wdata, vecs[i].rdata, r);
      check($sformatf("v%0d_lat", i), r.lat, vecs[i].exp_lat);
      check($sformatf("v%0d_pslverr", i), r.err, vecs[i].exp_err);
      check($sformatf("v%0d_pkts", i), r.pkts, 0);
      if (vecs[i].exp_err) begin
        check($sformatf("v%0d_no_strobe", i), r.strobe_n, -1);
      end else begin
        check($sformatf("v%0d_strobe_cycle", i), r.strobe_n, 1);
        check($sformatf("v%0d_rb_addr", i), r.s_addr, vecs[i].exp_addr);
        check($sformatf("v%0d_is_write", i), r.s_wr, vecs[i].wr);
        if (vecs[i].wr) check($sformatf("v%0d_rb_wdata", i), r.s_wdata, vecs[i].wdata);
        else            check($sformatf("v%0d_prdata", i), r.prdata, vecs[i].rdata);
      end
    end

    // FIFO kept non-empty while an APB write waits: four packet pops, then APB
    push_en = 1'b1;
    repeat (4) tick();
    check("t4_fifo_nonempty", prx_fifo_lvl_out != 3'd0, 1'b1);
    apb_xfer(40'h020, 1'b1, 32'hA0A0_0004, 32'h0, r);
    check("t4_pkts_before", r.pkts, 4);
    check("t4_strobe_cycle", r.strobe_n, 5);
    check("t4_rb_addr", r.s_addr, 8'h08);
    check("t4_lat", r.lat, 6);

    // Back-to-back reads while packets are pushed every cycle
    for (int i = 0; i < 6; i++) begin
      apb_xfer(40'h0C0 + 40'(4 * i), 1'b0, 32'h0, 32'h3000_0000 + i, r);
      check($sformatf("t3_%0d_lat", i), r.lat, 7);
      check($sformatf("t3_%0d_rb_addr", i), r.s_addr, 8'h30 + 8'(i));
      check($sformatf("t3_%0d_prdata", i), r.prdata, 32'h3000_0000 + i);
    end
    check("t3_max_lvl", max_lvl, 4);
    push_en = 1'b0;
    waited = 0;
    while (prx_fifo_lvl_out != 3'd0 && waited < 20) begin
      tick();
      waited++;
    end
    repeat (2) tick();
    check("t3_drained_lvl", prx_fifo_lvl_out, 3'd0);
    check("t3_all_pkts_seen", exp_q.size(), 0);

    // Reset during RD_WAIT with packets queued
    push_en = 1'b1;
    repeat (3) apb_xfer(40'h0C8, 1'b0, 32'h0, 32'h1, r);
    tick();
    apb_psel_in = 1'b1; apb_penable_in = 1'b0; apb_pwrite_in = 1'b0; apb_paddr_in = 40'h0C8;
    tick();
    apb_penable_in = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      seen = rb_ren_out;
    end
    check("t6_ren_seen", seen, 1'b1);
    tick();
    check("t6_lvl_before_rst", prx_fifo_lvl_out != 3'd0, 1'b1);
    resetn = 1'b0; push_en = 1'b0; apb_psel_in = 1'b0; apb_penable_in = 1'b0;
    tick();
    check("t6_wen", rb_wen_out, 1'b0);
    check("t6_ren", rb_ren_out, 1'b0);
    check("t6_pready", apb_pready_out, 1'b0);
    check("t6_prdata", apb_prdata_out, 32'h0);
    check("t6_rdy", prx_rdy_out, 1'b0);
    check("t6_lvl", prx_fifo_lvl_out, 3'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    apb_xfer(40'h030, 1'b1, 32'hA0A0_0006, 32'h0, r);
    check("t6_post_lat", r.lat, 2);
    check("t6_post_strobe", r.strobe_n, 1);
    check("t6_post_addr", r.s_addr, 8'h0C);
    check("t6_post_wdata", r.s_wdata, 32'hA0A0_0006);
    check("t6_post_pkts", r.pkts, 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
